// File: rtl/text_pkg.sv
// Shared geometry, control codes, cell format and state encoding for the
// text console writer.
package text_pkg;

   localparam int ROW_STRIDE = 32;
   localparam int ADDR_W     = 10;
   localparam int COL_W      = $clog2(ROW_STRIDE);
   localparam int ROW_W      = ADDR_W - COL_W;

   localparam logic [4:0] COL_FIRST = 5'd1;
   localparam logic [4:0] COL_LAST  = 5'd28;
   localparam logic [4:0] ROW_FIRST = 5'd1;
   localparam logic [4:0] ROW_LAST  = 5'd15;

   localparam logic [7:0] CODE_CR = 8'h0D;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_FF = 8'h0C;

   typedef struct packed {
      logic [7:0] attr;
      logic [7:0] chr;
   } cell_t;

   localparam cell_t BLANK_CELL = '{attr: 8'h07, chr: 8'h20};

   typedef enum logic [1:0] {
      IDLE,
      CLEAR_LINE,
      CLEAR_ALL
   } state_t;

   // Row stride is a power of two, so the cell address is a plain concat.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream front end for the text RAM write port: cursor tracking, control
// codes, line wrap and line/screen clears.
//
// state      | meaning
// IDLE       | accepting bytes; printable and BS writes issue from here
// CLEAR_LINE | blanking columns COL_FIRST..COL_LAST of the new cursor row
// CLEAR_ALL  | blanking the whole window row by row after a form feed
module text_console_writer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_attr,
   output logic        ram_cea,
   output logic [9:0]  ram_ada,
   output logic [15:0] ram_din,
   output logic [4:0]  cur_row,
   output logic [4:0]  cur_col,
   output logic        busy
);
   import text_pkg::*;

   state_t     state;
   logic [4:0] clr_row;
   logic [4:0] clr_col;
   logic       clr_done;

   logic       accept;
   logic       is_ctrl;
   logic       newline;
   logic [4:0] nl_row;

   always_comb begin
      accept  = in_valid && in_ready;
      is_ctrl = (in_data == CODE_CR) || (in_data == CODE_LF) ||
                (in_data == CODE_BS) || (in_data == CODE_FF);
      newline = accept && ((in_data == CODE_LF) || (!is_ctrl && (cur_col == COL_LAST)));
      nl_row  = (cur_row == ROW_LAST) ? ROW_FIRST : cur_row + 5'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur_row  <= ROW_FIRST;
         cur_col  <= COL_FIRST;
         ram_cea  <= 1'b0;
         ram_ada  <= '0;
         ram_din  <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         clr_row  <= ROW_FIRST;
         clr_col  <= COL_FIRST;
         clr_done <= 1'b0;
      end else begin
         ram_cea <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               if (newline) begin
                  cur_row  <= nl_row;
                  cur_col  <= COL_FIRST;
                  clr_col  <= COL_FIRST;
                  state    <= CLEAR_LINE;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
               if (accept) begin
                  if (in_data == CODE_CR) begin
                     cur_col <= COL_FIRST;
                  end else if (in_data == CODE_BS) begin
                     if (cur_col > COL_FIRST) begin
                        cur_col <= cur_col - 5'd1;
                        ram_cea <= 1'b1;
                        ram_ada <= cell_addr(cur_row, cur_col - 5'd1);
                        ram_din <= BLANK_CELL;
                     end
                  end else if (in_data == CODE_FF) begin
                     cur_row  <= ROW_FIRST;
                     cur_col  <= COL_FIRST;
                     clr_row  <= ROW_FIRST;
                     clr_col  <= COL_FIRST;
                     state    <= CLEAR_ALL;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else if (in_data != CODE_LF) begin
                     ram_cea <= 1'b1;
                     ram_ada <= cell_addr(cur_row, cur_col);
                     ram_din <= {in_attr, in_data};
                     if (!newline) cur_col <= cur_col + 5'd1;
                  end
               end
            end
            CLEAR_LINE: begin
               // One idle cycle after the last write so in_ready never overlaps it.
               if (clr_done) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  clr_done <= 1'b0;
               end else begin
                  ram_cea <= 1'b1;
                  ram_ada <= cell_addr(cur_row, clr_col);
                  ram_din <= BLANK_CELL;
                  if (clr_col == COL_LAST) clr_done <= 1'b1;
                  else                     clr_col  <= clr_col + 5'd1;
               end
            end
            CLEAR_ALL: begin
               if (clr_done) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  clr_done <= 1'b0;
               end else begin
                  ram_cea <= 1'b1;
                  ram_ada <= cell_addr(clr_row, clr_col);
                  ram_din <= BLANK_CELL;
                  if (clr_col == COL_LAST) begin
                     clr_col <= COL_FIRST;
                     if (clr_row == ROW_LAST) clr_done <= 1'b1;
                     else                     clr_row  <= clr_row + 5'd1;
                  end else begin
                     clr_col <= clr_col + 5'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: captures every RAM write and checks
// addresses, data, cursor and handshake against hand-computed values.
module tb_text_console_writer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [7:0]  in_attr;
   logic        ram_cea;
   logic [9:0]  ram_ada;
   logic [15:0] ram_din;
   logic [4:0]  cur_row;
   logic [4:0]  cur_col;
   logic        busy;

   text_console_writer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_attr  (in_attr),
      .ram_cea  (ram_cea),
      .ram_ada  (ram_ada),
      .ram_din  (ram_din),
      .cur_row  (cur_row),
      .cur_col  (cur_col),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  ada;
      logic [15:0] din;
      logic        rdy;
   } wr_t;

   wr_t wr_q[$];
   int  bad_wr;
   int  checks;
   int  failures;

   always @(negedge clk) begin
      if (ram_cea) begin
         wr_q.push_back('{ada: ram_ada, din: ram_din, rdy: in_ready});
         if (ram_ada[4:0] < 5'd1 || ram_ada[4:0] > 5'd28 ||
             ram_ada[9:5] < 5'd1 || ram_ada[9:5] > 5'd15)
            bad_wr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] a);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      in_attr  = a;
      n = 0;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("send_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      settle();
   endtask

   initial begin
      int errs;
      int idx;
      checks   = 0;
      failures = 0;
      bad_wr   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_attr  = 8'h00;

      // reset values while rst is held
      #12;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_cea", ram_cea, 1'b0);
      chk("rst_ada", ram_ada, 10'h000);
      chk("rst_din", ram_din, 16'h0000);
      chk("rst_row", cur_row, 5'd1);
      chk("rst_col", cur_col, 5'd1);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // single printable at home
      send(8'h41, 8'h0F);
      chk("p1_cea_timing", ram_cea, 1'b1);
      settle();
      chk("p1_count", wr_q.size(), 1);
      if (wr_q.size() == 1) begin
         chk("p1_ada", wr_q[0].ada, 10'h021);
         chk("p1_din", wr_q[0].din, 16'h0F41);
      end
      chk("p1_row", cur_row, 5'd1);
      chk("p1_col", cur_col, 5'd2);

      // a full line from home wraps and clears row 2
      do_reset();
      wr_q.delete();
      for (int i = 0; i < 28; i++) send(8'h30 + 8'(i), 8'h07);
      wait_idle(100);
      chk("line_ready_end_cea", ram_cea, 1'b0);
      chk("line_count", wr_q.size(), 56);
      if (wr_q.size() == 56) begin
         errs = 0;
         for (int i = 0; i < 28; i++) begin
            if (wr_q[i].ada !== 10'h021 + 10'(i)) errs++;
            if (wr_q[i].din !== {8'h07, 8'h30 + 8'(i)}) errs++;
            if (wr_q[28+i].ada !== 10'h041 + 10'(i)) errs++;
            if (wr_q[28+i].din !== 16'h0720) errs++;
            if (wr_q[28+i].rdy !== 1'b0) errs++;
         end
         chk("line_seq_errs", errs, 0);
      end
      chk("line_row", cur_row, 5'd2);
      chk("line_col", cur_col, 5'd1);

      // move to (15,5) then LF wraps to row 1
      for (int i = 0; i < 13; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < 4; i++) send(8'h78, 8'h1E);
      settle();
      chk("pre_wrap_row", cur_row, 5'd15);
      chk("pre_wrap_col", cur_col, 5'd5);
      wr_q.delete();
      send(8'h0A, 8'h00);
      wait_idle(100);
      chk("wrap_count", wr_q.size(), 28);
      if (wr_q.size() == 28) begin
         errs = 0;
         for (int i = 0; i < 28; i++) begin
            if (wr_q[i].ada !== 10'h021 + 10'(i)) errs++;
            if (wr_q[i].din !== 16'h0720) errs++;
         end
         chk("wrap_seq_errs", errs, 0);
      end
      chk("wrap_row", cur_row, 5'd1);
      chk("wrap_col", cur_col, 5'd1);
      wr_q.delete();
      send(8'h0D, 8'h00);
      settle();
      chk("cr_home_count", wr_q.size(), 0);
      chk("cr_home_col", cur_col, 5'd1);
      send(8'h61, 8'h07);
      send(8'h62, 8'h07);
      send(8'h0D, 8'h00);
      settle();
      chk("cr_mid_col", cur_col, 5'd1);
      chk("cr_mid_row", cur_row, 5'd1);

      // backspace at first column and mid-line
      send(8'h0A, 8'h00);
      wait_idle(100);
      send(8'h0A, 8'h00);
      wait_idle(100);
      wr_q.delete();
      send(8'h08, 8'h00);
      settle();
      chk("bs_edge_count", wr_q.size(), 0);
      chk("bs_edge_col", cur_col, 5'd1);
      chk("bs_edge_row", cur_row, 5'd3);
      for (int i = 0; i < 3; i++) send(8'h7A, 8'h07);
      settle();
      wr_q.delete();
      send(8'h08, 8'h00);
      settle();
      chk("bs_count", wr_q.size(), 1);
      if (wr_q.size() == 1) begin
         chk("bs_ada", wr_q[0].ada, 10'h063);
         chk("bs_din", wr_q[0].din, 16'h0720);
      end
      chk("bs_col", cur_col, 5'd3);

      // form feed clears the whole window
      wr_q.delete();
      send(8'h0C, 8'h00);
      chk("ff_row", cur_row, 5'd1);
      chk("ff_col", cur_col, 5'd1);
      chk("ff_busy", busy, 1'b1);
      chk("ff_ready", in_ready, 1'b0);
      wait_idle(1000);
      chk("ff_busy_end", busy, 1'b0);
      chk("ff_count", wr_q.size(), 420);
      if (wr_q.size() == 420) begin
         errs = 0;
         idx  = 0;
         for (int r = 1; r <= 15; r++) begin
            for (int c = 1; c <= 28; c++) begin
               if (wr_q[idx].ada !== {5'(r), 5'(c)}) errs++;
               if (wr_q[idx].din !== 16'h0720) errs++;
               idx++;
            end
         end
         chk("ff_seq_errs", errs, 0);
      end

      // reset in the middle of a full clear
      send(8'h0C, 8'h00);
      repeat (100) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_cea", ram_cea, 1'b0);
      chk("mid_rst_ada", ram_ada, 10'h000);
      chk("mid_rst_din", ram_din, 16'h0000);
      chk("mid_rst_ready", in_ready, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_row", cur_row, 5'd1);
      chk("mid_rst_col", cur_col, 5'd1);
      @(negedge clk);
      rst = 1'b0;
      wr_q.delete();
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      repeat (500) @(negedge clk);
      chk("post_rst_writes", wr_q.size(), 0);
      chk("post_rst_busy", busy, 1'b0);

      chk("out_of_window_writes", bad_wr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
